spi_rx_trig_param: RTL and testbench
====================================

Name: spi_rx_trig_param

Overview:
Parametrised SPI receive-side trigger for the logic analyzer.
- Passively snoops an SPI bus (SS_n, SCLK, MOSI) oversampled by the system clock.
- Captures frames of programmable length 1..MAX_LEN, either MSB-first or LSB-first.
- Issues a one-cycle trigger pulse when a correctly sized frame matches a masked pattern.
- Also reports captured data, frame-valid and frame-error strobes to the trigger/capture logic.

Parameters:
MAX_LEN, 32, maximum frame length in bits; width of mask/match/rx_data
SYNC_STAGES, 2, synchronizer depth for SS_n/SCLK/MOSI (min 2)
LENW, $clog2(MAX_LEN), width of len_m1 (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
SS_n  input  1  SPI slave select, active-low, async to clk
SCLK  input  1  SPI clock, async
MOSI  input  1  SPI data, async
edg  input  1  1 = sample on SCLK rise, 0 = sample on fall
lsb_first  input  1  1 = first bit received is bit 0
len_m1  input  LENW  frame length minus one
mask  input  MAX_LEN  1 = bit participates in compare
match  input  MAX_LEN  compare pattern
trig  output  1  one-cycle pulse on matching valid frame
rx_valid  output  1  one-cycle pulse on correctly sized frame
frame_err  output  1  one-cycle pulse on short/over-length frame
rx_data  output  MAX_LEN  last valid frame, right-aligned, upper bits zero

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- Reset values: trig=0, rx_valid=0, frame_err=0, rx_data=0, state=IDLE, armed=0. SS_n synchronizer flops reset to 1. SCLK/MOSI flops reset to 0.
- Synchronizers: SYNC_STAGES flops per input. SCLK and MOSI get one extra stage so data is aligned with edge detect. Sample edge = edg ? rise : fall, from the last two SCLK stages.
- armed: set in IDLE when synced SS_n=1; cleared by reset. A frame already in progress at reset release is ignored.
- IDLE -> RX: when armed and synced SS_n=0.
  - Latch edg, lsb_first, len_m1.
  - Clear shift register, bit_cnt, ovf.
- RX, on each sample edge with synced SS_n=0:
  - MSB-first: sr <= {sr[MAX_LEN-2:0], bit}.
  - LSB-first: sr[bit_cnt] <= bit.
  - If bit_cnt == len+1 already, no write and set ovf. Otherwise bit_cnt++.
  - bit_cnt width is LENW+1; it never exceeds len+1.
- RX -> IDLE: when synced SS_n=1. A sample edge in that same cycle is ignored. Frame evaluation happens in the next cycle (registered outputs):
  - bit_cnt == len+1 and !ovf: rx_valid=1 and rx_data <= sr.
    - trig = ((sr ^ match) & mask & lenmask) == 0, where lenmask has the low len+1 bits set.
    - mask and match are sampled at this evaluation, not at frame start.
  - Otherwise: frame_err=1, trig=0, rx_data unchanged.
- Latency: SS_n pin rise to strobe = SYNC_STAGES+1 clk.
- Strobes last exactly one cycle. rx_data holds until the next valid frame.
- SCLK activity while in IDLE is ignored.
- Config changes mid-frame have no effect until the next frame.
- Reset mid-frame: immediate return to IDLE, no strobe. A new frame starts only after SS_n is seen high.
- Minimum SCLK high/low time is 2 clk periods. Faster SCLK is unsupported and not detected.

Decomposition:
- spi_trig_pkg: state_t enum {IDLE, RX}; constant SYNC_MIN=2.
- Sub-module spi_sync_edge: parametrised synchronizer with reset value and rise/fall outputs. Instantiated for SS_n and SCLK; plain sync chain for MOSI.

Test Plan:
1. MAX_LEN=32, len_m1=7, edg=1, MSB-first, send 0xA5, mask=0xFF, match=0xA5 -> rx_valid=1, trig=1, rx_data=0x000000A5.
2. Same frame with match=0xA4, mask=0xFE -> trig=1. With mask=0x01 -> trig=0 and rx_valid=1.
3. len_m1=15, lsb_first=1, edg=0, send bits of 0x1234 LSB-first -> rx_data=0x00001234, trig per match=0x1234.
4. len_m1=7, send 6 bits -> frame_err=1, rx_valid=0, trig=0, rx_data retains the previous value. Send 9 bits -> frame_err=1.
5. len_m1=31, send 0xDEADBEEF, match=0xDEADBEEF, mask=all ones -> trig=1, exactly one cycle, SYNC_STAGES+1 clk after the SS_n rise.
6. Assert rst after 4 of 8 bits while SS_n stays low, release -> no strobes until SS_n goes high. The next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/spi_trig_pkg.sv
// -----------------------------------------------------------------------------
// spi_trig_pkg
// Shared definitions for the SPI receive-side trigger.
//   state_t  : receiver FSM state (IDLE waiting for a frame, RX inside a frame)
//   SYNC_MIN : smallest usable synchronizer depth
// -----------------------------------------------------------------------------
package spi_trig_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RX   = 1'b1
  } state_t;

  localparam int SYNC_MIN = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for one asynchronous input, with edge strobes taken
// from the last two stages.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous input
//   sync     : synchronized level (last stage)
//   rise     : one-cycle pulse, last-but-one stage high while last stage low
//   fall     : one-cycle pulse, last-but-one stage low while last stage high
// Parameters: STAGES (>= 2) flop count, RST_VAL value loaded by reset.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] q_r;

  // Shift chain: stage 0 takes the raw pin, the highest stage is the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {STAGES{RST_VAL}};
    end else begin
      q_r <= {q_r[STAGES-2:0], din};
    end
  end

  assign sync = q_r[STAGES-1];
  assign rise = q_r[STAGES-2] & ~q_r[STAGES-1];
  assign fall = ~q_r[STAGES-2] & q_r[STAGES-1];

endmodule

// File: rtl/spi_rx_trig_param.sv
// -----------------------------------------------------------------------------
// spi_rx_trig_param
// Passive SPI receive-side trigger. Snoops SS_n/SCLK/MOSI oversampled by clk,
// captures a frame of len_m1+1 bits (MSB- or LSB-first) and compares it with a
// masked pattern when SS_n returns high.
//   clk, rst        : system clock, asynchronous active-high reset
//   SS_n/SCLK/MOSI  : SPI bus, asynchronous to clk
//   edg             : 1 = sample on SCLK rise, 0 = on fall   (latched per frame)
//   lsb_first       : 1 = first received bit lands in bit 0  (latched per frame)
//   len_m1          : frame length minus one                 (latched per frame)
//   mask, match     : compare mask/pattern, sampled at frame evaluation
//   trig            : one-cycle pulse, valid frame matched
//   rx_valid        : one-cycle pulse, correctly sized frame
//   frame_err       : one-cycle pulse, short or over-length frame
//   rx_data         : last valid frame, right-aligned, held until the next one
// -----------------------------------------------------------------------------
module spi_rx_trig_param
  import spi_trig_pkg::*;
#(
  parameter  int MAX_LEN     = 32,
  parameter  int SYNC_STAGES = 2,
  localparam int LENW        = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  input  logic               edg,
  input  logic               lsb_first,
  input  logic [LENW-1:0]    len_m1,
  input  logic [MAX_LEN-1:0] mask,
  input  logic [MAX_LEN-1:0] match,
  output logic               trig,
  output logic               rx_valid,
  output logic               frame_err,
  output logic [MAX_LEN-1:0] rx_data
);

  localparam int               SYNC_N   = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
  localparam logic [MAX_LEN-1:0] ALL_ONES = {MAX_LEN{1'b1}};

  logic               ss_sync_s, ss_rise_s, ss_fall_s;
  logic               sclk_sync_s, sclk_rise_s, sclk_fall_s;
  logic               unused_edges_s;
  logic [SYNC_N:0]    mosi_q_r;
  logic [SYNC_N-1:0]  fill_r;
  logic               mosi_bit_s;
  logic               sample_s;
  logic [LENW:0]      len_p1_s;
  logic               full_s;
  logic [MAX_LEN-1:0] lenmask_s;
  logic               hit_s;

  state_t             state_r;
  logic               armed_r;
  logic               edg_r;
  logic               lsb_r;
  logic [LENW-1:0]    len_r;
  logic [MAX_LEN-1:0] sr_r;
  logic [LENW:0]      bit_cnt_r;
  logic               ovf_r;
  logic               trig_r;
  logic               rx_valid_r;
  logic               frame_err_r;
  logic [MAX_LEN-1:0] rx_data_r;

  // SS_n idles high, so its chain resets to 1.
  spi_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SS_n),
    .sync (ss_sync_s),
    .rise (ss_rise_s),
    .fall (ss_fall_s)
  );

  // SCLK carries one extra stage so its edges line up with the MOSI chain.
  spi_sync_edge #(.STAGES(SYNC_N + 1), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCLK),
    .sync (sclk_sync_s),
    .rise (sclk_rise_s),
    .fall (sclk_fall_s)
  );

  assign unused_edges_s = ^{ss_rise_s, ss_fall_s, sclk_sync_s};

  // MOSI synchronizer, same depth as SCLK; the last stage holds the bit that
  // was on the wire just before the detected SCLK edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_q_r <= {(SYNC_N + 1){1'b0}};
    end else begin
      mosi_q_r <= {mosi_q_r[SYNC_N-1:0], MOSI};
    end
  end

  // The SS_n chain holds its reset value until SYNC_N real samples have passed
  // through it; arming waits for that so a frame already running at reset
  // release is not mistaken for an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_r <= {SYNC_N{1'b0}};
    end else begin
      fill_r <= {fill_r[SYNC_N-2:0], 1'b1};
    end
  end

  assign mosi_bit_s = mosi_q_r[SYNC_N];
  assign sample_s   = edg_r ? sclk_rise_s : sclk_fall_s;
  assign len_p1_s   = {1'b0, len_r} + {{LENW{1'b0}}, 1'b1};
  assign full_s     = (bit_cnt_r == len_p1_s);
  // Shifting by MAX_LEN yields zero, giving an all-ones mask for full length.
  assign lenmask_s  = ~(ALL_ONES << len_p1_s);
  assign hit_s      = (((sr_r ^ match) & mask & lenmask_s) == {MAX_LEN{1'b0}});

  // Receive FSM, frame capture and registered frame evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      armed_r     <= 1'b0;
      edg_r       <= 1'b0;
      lsb_r       <= 1'b0;
      len_r       <= {LENW{1'b0}};
      sr_r        <= {MAX_LEN{1'b0}};
      bit_cnt_r   <= {(LENW + 1){1'b0}};
      ovf_r       <= 1'b0;
      trig_r      <= 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      rx_data_r   <= {MAX_LEN{1'b0}};
    end else begin
      trig_r      <= 1'b0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fill_r[SYNC_N-1] && ss_sync_s) begin
            armed_r <= 1'b1;
          end
          if (armed_r && !ss_sync_s) begin
            state_r   <= RX;
            edg_r     <= edg;
            lsb_r     <= lsb_first;
            len_r     <= len_m1;
            sr_r      <= {MAX_LEN{1'b0}};
            bit_cnt_r <= {(LENW + 1){1'b0}};
            ovf_r     <= 1'b0;
          end
        end
        RX: begin
          if (ss_sync_s) begin
            // End of frame; a sample edge in this cycle is dropped.
            state_r <= IDLE;
            if (full_s && !ovf_r) begin
              rx_valid_r <= 1'b1;
              rx_data_r  <= sr_r;
              trig_r     <= hit_s;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else if (sample_s) begin
            if (full_s) begin
              ovf_r <= 1'b1;
            end else begin
              if (lsb_r) begin
                sr_r[bit_cnt_r[LENW-1:0]] <= mosi_bit_s;
              end else begin
                sr_r <= {sr_r[MAX_LEN-2:0], mosi_bit_s};
              end
              bit_cnt_r <= bit_cnt_r + {{LENW{1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign trig      = trig_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign rx_data   = rx_data_r;

endmodule

// File: tb/tb_spi_rx_trig_param.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_trig_param
// Directed bench for spi_rx_trig_param. Frames are bit-banged on the SPI pins;
// a frame-level model predicts the strobe cycle and values, and a negedge
// process compares every output on every cycle.
// -----------------------------------------------------------------------------
module tb_spi_rx_trig_param;

  localparam int MAX_LEN = 32;
  localparam int SYNC    = 2;
  localparam int LENW    = 5;
  localparam int HALF    = 4;

  logic               clk       = 1'b0;
  logic               rst       = 1'b1;
  logic               SS_n      = 1'b1;
  logic               SCLK      = 1'b0;
  logic               MOSI      = 1'b0;
  logic               edg       = 1'b1;
  logic               lsb_first = 1'b0;
  logic [LENW-1:0]    len_m1    = 5'd7;
  logic [MAX_LEN-1:0] mask      = 32'h0;
  logic [MAX_LEN-1:0] match     = 32'h0;
  logic               trig;
  logic               rx_valid;
  logic               frame_err;
  logic [MAX_LEN-1:0] rx_data;

  spi_rx_trig_param #(.MAX_LEN(MAX_LEN), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .edg       (edg),
    .lsb_first (lsb_first),
    .len_m1    (len_m1),
    .mask      (mask),
    .match     (match),
    .trig      (trig),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Frame-level model state
  int          exp_cyc     = -1;
  bit          exp_ok      = 1'b0;
  bit          exp_trig    = 1'b0;
  logic [31:0] exp_data    = 32'h0;
  logic [31:0] exp_rx      = 32'h0;
  int          ss_rise_cyc = 0;

  // Values seen at the predicted strobe cycle, plus trig pulse history
  logic obs_trig  = 1'b0;
  logic obs_valid = 1'b0;
  logic obs_err   = 1'b0;
  int   trig_pulses   = 0;
  int   last_trig_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin : compare
    bit strobe_now, ev, ee, et;
    forever begin
      @(negedge clk);
      strobe_now = (rst == 1'b0) && (cyc == exp_cyc);
      ev = strobe_now && exp_ok;
      ee = strobe_now && !exp_ok;
      et = ev && exp_trig;
      if (rst) exp_rx = 32'h0;
      else if (ev) exp_rx = exp_data;
      chk("rx_valid", {31'b0, rx_valid}, {31'b0, ev});
      chk("frame_err", {31'b0, frame_err}, {31'b0, ee});
      chk("trig", {31'b0, trig}, {31'b0, et});
      chk("rx_data", rx_data, exp_rx);
      if (strobe_now) begin
        obs_trig  = trig;
        obs_valid = rx_valid;
        obs_err   = frame_err;
      end
      if (trig === 1'b1) begin
        trig_pulses++;
        last_trig_cyc = cyc;
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit e);
    if (e) begin
      MOSI = b; clks(HALF);
      SCLK = 1'b1; clks(HALF);
      SCLK = 1'b0;
    end else begin
      SCLK = 1'b1; MOSI = b; clks(HALF);
      SCLK = 1'b0; clks(HALF);
    end
  endtask

  // Send nbits of value in the configured order; optionally disturb the
  // configuration mid-frame, which must not affect this frame.
  task automatic frame(input int nbits, input logic [31:0] value, input bit scramble);
    logic [LENW-1:0] len_v;
    bit lsb_v, edg_v;
    logic [31:0] lm;
    len_v = len_m1; lsb_v = lsb_first; edg_v = edg;
    SS_n = 1'b0;
    clks(HALF);
    if (scramble) begin
      len_m1 = ~len_v; lsb_first = ~lsb_v; edg = ~edg_v;
    end
    for (int i = 0; i < nbits; i++)
      send_bit(lsb_v ? value[i] : value[nbits-1-i], edg_v);
    clks(HALF);
    SS_n = 1'b1;
    ss_rise_cyc = cyc;
    lm       = (len_v == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (len_v + 5'd1)) - 32'd1);
    exp_ok   = (nbits == int'(len_v) + 1);
    exp_data = value & lm;
    exp_trig = exp_ok && (((exp_data ^ match) & mask & lm) == 32'h0);
    exp_cyc  = cyc + SYNC + 1;
    clks(SYNC + 4);
    len_m1 = len_v; lsb_first = lsb_v; edg = edg_v;
  endtask

  initial begin
    int pulses_before;
    clks(3);
    rst = 1'b0;
    clks(4);
    chk("reset_rx_data", rx_data, 32'h0);
    chk("reset_trig", {31'b0, trig}, 32'h0);
    chk("reset_rx_valid", {31'b0, rx_valid}, 32'h0);

    // SCLK toggling with SS_n high must be ignored.
    for (int i = 0; i < 3; i++) begin
      SCLK = 1'b1; clks(HALF); SCLK = 1'b0; clks(HALF);
    end

    // 1: MSB-first 0xA5, rising edge
    len_m1 = 5'd7; edg = 1'b1; lsb_first = 1'b0;
    mask = 32'hFF; match = 32'hA5;
    frame(8, 32'hA5, 1'b0);
    chk("t1_trig", {31'b0, obs_trig}, 32'h1);
    chk("t1_valid", {31'b0, obs_valid}, 32'h1);
    chk("t1_data", rx_data, 32'h0000_00A5);

    // Pattern bits above the frame length are ignored
    mask = 32'hFFFF_FFFF; match = 32'hABCD_EFA5;
    frame(8, 32'hA5, 1'b0);
    chk("t1b_trig", {31'b0, obs_trig}, 32'h1);

    // 2: masked compare
    mask = 32'hFE; match = 32'hA4;
    frame(8, 32'hA5, 1'b0);
    chk("t2a_trig", {31'b0, obs_trig}, 32'h1);
    mask = 32'h01;
    frame(8, 32'hA5, 1'b0);
    chk("t2b_trig", {31'b0, obs_trig}, 32'h0);
    chk("t2b_valid", {31'b0, obs_valid}, 32'h1);

    // 3: 16-bit LSB-first on falling edge, config disturbed mid-frame
    len_m1 = 5'd15; lsb_first = 1'b1; edg = 1'b0;
    mask = 32'hFFFF_FFFF; match = 32'h1234;
    frame(16, 32'h1234, 1'b1);
    chk("t3_trig", {31'b0, obs_trig}, 32'h1);
    chk("t3_data", rx_data, 32'h0000_1234);

    // 4: short and over-length frames
    len_m1 = 5'd7; lsb_first = 1'b0; edg = 1'b1;
    mask = 32'h0; match = 32'h0;
    frame(6, 32'h2A, 1'b0);
    chk("t4_short_err", {31'b0, obs_err}, 32'h1);
    chk("t4_short_valid", {31'b0, obs_valid}, 32'h0);
    chk("t4_short_trig", {31'b0, obs_trig}, 32'h0);
    chk("t4_retain", rx_data, 32'h0000_1234);
    frame(9, 32'h155, 1'b0);
    chk("t4_long_err", {31'b0, obs_err}, 32'h1);

    // 5: full 32-bit frame, pulse width and latency
    len_m1 = 5'd31; mask = 32'hFFFF_FFFF; match = 32'hDEAD_BEEF;
    pulses_before = trig_pulses;
    frame(32, 32'hDEAD_BEEF, 1'b0);
    chk("t5_trig", {31'b0, obs_trig}, 32'h1);
    chk("t5_data", rx_data, 32'hDEAD_BEEF);
    chk("t5_one_pulse", trig_pulses - pulses_before, 32'd1);
    chk("t5_latency", last_trig_cyc - ss_rise_cyc, 32'd3);

    // 6: reset in the middle of a frame
    len_m1 = 5'd7; mask = 32'hFF; match = 32'h3C;
    pulses_before = trig_pulses;
    SS_n = 1'b0; clks(HALF);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h3C >> (7 - i)), 1'b1);
    rst = 1'b1; clks(3); rst = 1'b0;
    for (int i = 4; i < 8; i++) send_bit(1'(8'h3C >> (7 - i)), 1'b1);
    clks(HALF);
    SS_n = 1'b1;
    clks(SYNC + 6);
    chk("t6_no_strobe", trig_pulses - pulses_before, 32'd0);
    chk("t6_rx_data_reset", rx_data, 32'h0);
    frame(8, 32'h3C, 1'b0);
    chk("t6_trig", {31'b0, obs_trig}, 32'h1);
    chk("t6_data", rx_data, 32'h0000_003C);

    clks(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
